// File: rtl/conv_stream_loader.sv
// Stream front-end for the convolution core: parses a two-byte header, loads the
// X/Y sample memories from the byte stream, then starts the core and waits for done.
module conv_stream_loader #(
   parameter int DATAWIDTH_X      = 8,
   parameter int DATAWIDTH_Y      = 8,
   parameter int MEM_ADDR_XY_SIZE = 5,
   parameter int SIZE_X           = 5,
   parameter int SIZE_Y           = 5
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [DATAWIDTH_X-1:0]      s_data,
   input  logic                        s_valid,
   output logic                        s_ready,
   output logic [MEM_ADDR_XY_SIZE-1:0] memX_waddr,
   output logic [DATAWIDTH_X-1:0]      memX_wdata,
   output logic                        memX_we,
   output logic [MEM_ADDR_XY_SIZE-1:0] memY_waddr,
   output logic [DATAWIDTH_Y-1:0]      memY_wdata,
   output logic                        memY_we,
   output logic [SIZE_X-1:0]           sizeX,
   output logic [SIZE_Y-1:0]           sizeY,
   output logic                        shape,
   output logic                        conv_start,
   input  logic                        conv_busy,
   input  logic                        conv_done,
   output logic                        busy,
   output logic                        frame_done,
   output logic                        err
);

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_HDR1   = 4'd1;
   localparam logic [3:0] ST_LOAD_X = 4'd2;
   localparam logic [3:0] ST_LOAD_Y = 4'd3;
   localparam logic [3:0] ST_FLUSH  = 4'd4;
   localparam logic [3:0] ST_START  = 4'd5;
   localparam logic [3:0] ST_RUN    = 4'd6;
   localparam logic [3:0] ST_DONE   = 4'd7;
   localparam logic [3:0] ST_ERR    = 4'd8;

   localparam logic [MEM_ADDR_XY_SIZE-1:0] CNT_ZERO = {MEM_ADDR_XY_SIZE{1'b0}};
   localparam logic [MEM_ADDR_XY_SIZE-1:0] CNT_ONE  = {{(MEM_ADDR_XY_SIZE-1){1'b0}}, 1'b1};
   localparam logic [SIZE_X-1:0]           SX_ZERO  = {SIZE_X{1'b0}};
   localparam logic [SIZE_X-1:0]           SX_ONE   = {{(SIZE_X-1){1'b0}}, 1'b1};
   localparam logic [SIZE_Y-1:0]           SY_ZERO  = {SIZE_Y{1'b0}};
   localparam logic [SIZE_Y-1:0]           SY_ONE   = {{(SIZE_Y-1){1'b0}}, 1'b1};

   logic [3:0]                  state_q, state_d;
   logic [MEM_ADDR_XY_SIZE-1:0] cnt_x_q, cnt_x_d;
   logic [MEM_ADDR_XY_SIZE-1:0] cnt_y_q, cnt_y_d;
   logic [SIZE_X-1:0]           size_x_q, size_x_d;
   logic [SIZE_Y-1:0]           size_y_q, size_y_d;
   logic                        shape_q, shape_d;
   logic                        s_ready_q, s_ready_d;
   logic                        memx_we_q, memx_we_d;
   logic [MEM_ADDR_XY_SIZE-1:0] memx_waddr_q, memx_waddr_d;
   logic [DATAWIDTH_X-1:0]      memx_wdata_q, memx_wdata_d;
   logic                        memy_we_q, memy_we_d;
   logic [MEM_ADDR_XY_SIZE-1:0] memy_waddr_q, memy_waddr_d;
   logic [DATAWIDTH_Y-1:0]      memy_wdata_q, memy_wdata_d;
   logic                        conv_start_q, conv_start_d;
   logic                        busy_q, busy_d;
   logic                        frame_done_q, frame_done_d;
   logic                        err_q, err_d;

   logic                        fire_s;
   logic                        last_x_s;
   logic                        last_y_s;
   logic                        hdr_bad_s;

   // States in which the stream is allowed to deliver a byte.
   function automatic logic accepts_bytes(input logic [3:0] st);
      logic acc;
      case (st)
         ST_IDLE, ST_HDR1, ST_LOAD_X, ST_LOAD_Y: acc = 1'b1;
         default:                                acc = 1'b0;
      endcase
      return acc;
   endfunction

   // Handshake qualifier and end-of-block detection for the sample counters.
   always_comb begin
      fire_s    = s_valid & s_ready_q;
      last_x_s  = (SIZE_X'(cnt_x_q) == (size_x_q - SX_ONE));
      last_y_s  = (SIZE_Y'(cnt_y_q) == (size_y_q - SY_ONE));
      hdr_bad_s = (size_x_q == SX_ZERO) || (s_data[SIZE_Y-1:0] == SY_ZERO);
   end

   // Frame sequencing: header parse, sample loading and core handshake.
   always_comb begin
      state_d      = state_q;
      cnt_x_d      = cnt_x_q;
      cnt_y_d      = cnt_y_q;
      size_x_d     = size_x_q;
      size_y_d     = size_y_q;
      shape_d      = shape_q;
      memx_we_d    = 1'b0;
      memx_waddr_d = memx_waddr_q;
      memx_wdata_d = memx_wdata_q;
      memy_we_d    = 1'b0;
      memy_waddr_d = memy_waddr_q;
      memy_wdata_d = memy_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (fire_s) begin
               size_x_d = s_data[SIZE_X-1:0];
               shape_d  = s_data[DATAWIDTH_X-1];
               state_d  = ST_HDR1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR1: begin
            if (fire_s) begin
               size_y_d = s_data[SIZE_Y-1:0];
               if (hdr_bad_s) begin
                  state_d = ST_ERR;
               end else begin
                  cnt_x_d = CNT_ZERO;
                  state_d = ST_LOAD_X;
               end
            end else begin
               state_d = ST_HDR1;
            end
         end
         ST_LOAD_X: begin
            if (fire_s) begin
               memx_we_d    = 1'b1;
               memx_waddr_d = cnt_x_q;
               memx_wdata_d = s_data;
               cnt_x_d      = cnt_x_q + CNT_ONE;
               if (last_x_s) begin
                  cnt_y_d = CNT_ZERO;
                  state_d = ST_LOAD_Y;
               end else begin
                  state_d = ST_LOAD_X;
               end
            end else begin
               state_d = ST_LOAD_X;
            end
         end
         ST_LOAD_Y: begin
            if (fire_s) begin
               memy_we_d    = 1'b1;
               memy_waddr_d = cnt_y_q;
               memy_wdata_d = s_data;
               cnt_y_d      = cnt_y_q + CNT_ONE;
               if (last_y_s) begin
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_LOAD_Y;
               end
            end else begin
               state_d = ST_LOAD_Y;
            end
         end
         // The flush cycle lets the final Y write land before start is visible.
         ST_FLUSH: state_d = ST_START;
         ST_START: begin
            if (conv_done) begin
               state_d = ST_DONE;
            end else if (conv_busy) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_START;
            end
         end
         ST_RUN: begin
            if (conv_done) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Status outputs are registered views of the next state.
   always_comb begin
      s_ready_d    = accepts_bytes(state_d);
      conv_start_d = (state_d == ST_START);
      busy_d       = (state_d != ST_IDLE);
      frame_done_d = (state_d == ST_DONE);
      err_d        = (state_d == ST_ERR);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         cnt_x_q      <= CNT_ZERO;
         cnt_y_q      <= CNT_ZERO;
         size_x_q     <= SX_ZERO;
         size_y_q     <= SY_ZERO;
         shape_q      <= 1'b0;
         s_ready_q    <= 1'b0;
         memx_we_q    <= 1'b0;
         memx_waddr_q <= CNT_ZERO;
         memx_wdata_q <= {DATAWIDTH_X{1'b0}};
         memy_we_q    <= 1'b0;
         memy_waddr_q <= CNT_ZERO;
         memy_wdata_q <= {DATAWIDTH_Y{1'b0}};
         conv_start_q <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_x_q      <= cnt_x_d;
         cnt_y_q      <= cnt_y_d;
         size_x_q     <= size_x_d;
         size_y_q     <= size_y_d;
         shape_q      <= shape_d;
         s_ready_q    <= s_ready_d;
         memx_we_q    <= memx_we_d;
         memx_waddr_q <= memx_waddr_d;
         memx_wdata_q <= memx_wdata_d;
         memy_we_q    <= memy_we_d;
         memy_waddr_q <= memy_waddr_d;
         memy_wdata_q <= memy_wdata_d;
         conv_start_q <= conv_start_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign s_ready    = s_ready_q;
   assign memX_we    = memx_we_q;
   assign memX_waddr = memx_waddr_q;
   assign memX_wdata = memx_wdata_q;
   assign memY_we    = memy_we_q;
   assign memY_waddr = memy_waddr_q;
   assign memY_wdata = memy_wdata_q;
   assign sizeX      = size_x_q;
   assign sizeY      = size_y_q;
   assign shape      = shape_q;
   assign conv_start = conv_start_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_conv_stream_loader.sv
// Self-checking bench for conv_stream_loader: randomized frames against a
// frame-level memory model plus a simple convolution core model.
module tb_conv_stream_loader;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic [4:0] memX_waddr, memY_waddr;
   logic [7:0] memX_wdata, memY_wdata;
   logic       memX_we, memY_we;
   logic [4:0] sizeX, sizeY;
   logic       shape, conv_start, conv_busy, conv_done, busy, frame_done, err;

   always #5 clk = ~clk;

   conv_stream_loader dut (
      .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .memX_waddr(memX_waddr), .memX_wdata(memX_wdata), .memX_we(memX_we),
      .memY_waddr(memY_waddr), .memY_wdata(memY_wdata), .memY_we(memY_we),
      .sizeX(sizeX), .sizeY(sizeY), .shape(shape), .conv_start(conv_start),
      .conv_busy(conv_busy), .conv_done(conv_done), .busy(busy),
      .frame_done(frame_done), .err(err)
   );

   wire [43:0] all_outs = {s_ready, memX_waddr, memX_wdata, memX_we, memY_waddr, memY_wdata,
                           memY_we, sizeX, sizeY, shape, conv_start, busy, frame_done, err};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [7:0] tx_q[$];
   int acc_edge[$];
   logic [7:0] obs_x[32];
   logic [7:0] obs_y[32];
   bit   obs_x_wr[32];
   bit   obs_y_wr[32];
   int wr_x_cnt, wr_y_cnt, start_rise_cyc, start_high_cnt, fd_cnt, fd_cyc, err_cnt;
   int ready_bad_cnt, last_y_we_cyc;
   logic prev_start = 1'b0;
   int core_mode = 0, core_phase = 0, core_timer = 0;

   task automatic clear_obs();
      for (int a = 0; a < 32; a++) begin
         obs_x[a] = 8'h00; obs_y[a] = 8'h00; obs_x_wr[a] = 1'b0; obs_y_wr[a] = 1'b0;
      end
      wr_x_cnt = 0; wr_y_cnt = 0; start_rise_cyc = -1; start_high_cnt = 0;
      fd_cnt = 0; fd_cyc = -1; err_cnt = 0; ready_bad_cnt = 0; last_y_we_cyc = -1;
      acc_edge.delete();
   endtask

   // One clock: observe outputs after the edge, then advance the core model.
   task automatic cycle();
      @(posedge clk);
      cyc++;
      #1;
      if (memX_we === 1'b1) begin
         obs_x[memX_waddr] = memX_wdata; obs_x_wr[memX_waddr] = 1'b1; wr_x_cnt++;
      end
      if (memY_we === 1'b1) begin
         obs_y[memY_waddr] = memY_wdata; obs_y_wr[memY_waddr] = 1'b1; wr_y_cnt++;
         last_y_we_cyc = cyc;
      end
      if (conv_start === 1'b1) begin
         start_high_cnt++;
         if (!prev_start && start_rise_cyc < 0) start_rise_cyc = cyc;
      end
      prev_start = (conv_start === 1'b1);
      if (frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
      if (err === 1'b1) err_cnt++;
      if (s_ready === 1'b1 && (conv_start === 1'b1 || conv_busy || frame_done === 1'b1))
         ready_bad_cnt++;
      if (core_phase == 0) begin
         if (conv_start === 1'b1) begin
            core_phase = 1; core_timer = 0; conv_busy = (core_mode == 0);
         end
      end else if (core_phase == 1) begin
         core_timer++;
         if (core_timer == ((core_mode == 0) ? 4 : 2)) begin
            conv_busy = 1'b0; conv_done = 1'b1; core_phase = 2;
         end
      end else begin
         conv_done = 1'b0; core_phase = 0;
      end
   endtask

   task automatic build_frame(input int sx, input int sy, input int shp);
      logic [7:0] b;
      tx_q.delete();
      b = 8'(shp * 128 + $urandom_range(0, 3) * 32 + sx); tx_q.push_back(b);
      b = 8'($urandom_range(0, 7) * 32 + sy);              tx_q.push_back(b);
      for (int i = 0; i < sx + sy; i++) begin
         b = 8'($urandom_range(0, 255)); tx_q.push_back(b);
      end
   endtask

   // Offer tx_q[0..n-1]; valid is random for indices below gap_lim when gappy.
   task automatic send_bytes(input int n, input bit gappy, input int gap_lim);
      int idx = 0;
      int guard = 0;
      bit fire;
      while (idx < n && guard < 4000) begin
         s_valid = (gappy && idx < gap_lim) ? ($urandom_range(0, 1) == 1) : 1'b1;
         s_data  = s_valid ? tx_q[idx] : 8'($urandom_range(0, 255));
         fire    = s_valid && (s_ready === 1'b1);
         cycle();
         if (fire) begin acc_edge.push_back(cyc); idx++; end
         guard++;
      end
      s_valid = 1'b0;
      if (idx < n) begin
         total++; bad++;
         $display("FAIL send_timeout: sent %0d want %0d", idx, n);
      end
   endtask

   task automatic wait_done(input int want_fd, input int want_err);
      int g = 0;
      while ((fd_cnt < want_fd || err_cnt < want_err) && g < 300) begin cycle(); g++; end
      if (g >= 300) begin
         total++; bad++;
         $display("FAIL wait_timeout: frame_done=%0d err=%0d", fd_cnt, err_cnt);
      end
      repeat (3) cycle();
   endtask

   // Expected memory image comes straight from the frame bytes.
   function automatic int model_mem_mismatch();
      int sx, sy, n;
      n  = 0;
      sx = int'(tx_q[0]) % 32;
      sy = int'(tx_q[1]) % 32;
      for (int a = 0; a < 32; a++) begin
         if (a < sx) begin
            if (!obs_x_wr[a] || obs_x[a] !== tx_q[2 + a]) n++;
         end else if (obs_x_wr[a]) n++;
         if (a < sy) begin
            if (!obs_y_wr[a] || obs_y[a] !== tx_q[2 + sx + a]) n++;
         end else if (obs_y_wr[a]) n++;
      end
      return n;
   endfunction

   task automatic test_reset();
      rstn = 1'b0; s_valid = 1'b1; s_data = 8'h55; conv_busy = 1'b0; conv_done = 1'b0;
      clear_obs();
      cycle(); cycle();
      total++; if (all_outs !== 44'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", all_outs); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", s_ready); end
      rstn = 1'b1; s_valid = 1'b0;
      cycle();
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", s_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_reset: got %b want 0", busy); end
   endtask

   task automatic load_nominal();
      tx_q.delete();
      tx_q.push_back(8'h0A); tx_q.push_back(8'h05);
      for (int i = 1; i <= 10; i++) tx_q.push_back(8'(i));
      for (int i = 1; i <= 5; i++)  tx_q.push_back(8'(i));
   endtask

   task automatic test_nominal();
      int mm;
      clear_obs(); load_nominal();
      send_bytes(17, 1'b0, 17);
      wait_done(1, 0);
      mm = model_mem_mismatch();
      total++; if (mm !== 0) begin bad++; $display("FAIL nom_mem: got %0d bad entries want 0", mm); end
      total++; if (sizeX !== 5'd10 || sizeY !== 5'd5 || shape !== 1'b0) begin
         bad++; $display("FAIL nom_sizes: got %0d/%0d/%b want 10/5/0", sizeX, sizeY, shape); end
      total++; if (acc_edge[16] - acc_edge[0] !== 16) begin
         bad++; $display("FAIL nom_no_stall: got %0d want 16", acc_edge[16] - acc_edge[0]); end
      total++; if (wr_x_cnt !== 10 || wr_y_cnt !== 5) begin
         bad++; $display("FAIL nom_we_count: got %0d/%0d want 10/5", wr_x_cnt, wr_y_cnt); end
      total++; if (last_y_we_cyc !== acc_edge[16]) begin
         bad++; $display("FAIL nom_we_latency: got %0d want %0d", last_y_we_cyc, acc_edge[16]); end
      total++; if (start_rise_cyc !== acc_edge[16] + 2 - 1) begin
         bad++; $display("FAIL nom_start_rise: got %0d want %0d", start_rise_cyc, acc_edge[16] + 1); end
      total++; if (start_high_cnt !== 1) begin bad++; $display("FAIL nom_start_len: got %0d want 1", start_high_cnt); end
      total++; if (fd_cnt !== 1 || fd_cyc !== start_rise_cyc + 5) begin
         bad++; $display("FAIL nom_frame_done: got %0d@%0d want 1@%0d", fd_cnt, fd_cyc, start_rise_cyc + 5); end
      total++; if (conv_start !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1 || err_cnt !== 0) begin
         bad++; $display("FAIL nom_idle: got start=%b busy=%b ready=%b err=%0d want 0/0/1/0",
                         conv_start, busy, s_ready, err_cnt); end
   endtask

   task automatic test_gappy();
      int mm;
      clear_obs(); load_nominal();
      tx_q.push_back(8'h00);
      send_bytes(18, 1'b1, 17);
      mm = model_mem_mismatch();
      total++; if (mm !== 0) begin bad++; $display("FAIL gap_mem: got %0d bad entries want 0", mm); end
      total++; if (ready_bad_cnt !== 0) begin bad++; $display("FAIL gap_ready_in_run: got %0d want 0", ready_bad_cnt); end
      total++; if (start_rise_cyc !== acc_edge[16] + 1) begin
         bad++; $display("FAIL gap_start_rise: got %0d want %0d", start_rise_cyc, acc_edge[16] + 1); end
      total++; if (fd_cnt !== 1 || acc_edge[17] !== fd_cyc + 2) begin
         bad++; $display("FAIL gap_held_byte: got fd=%0d edge=%0d want 1/%0d", fd_cnt, acc_edge[17], fd_cyc + 2); end
      total++; if (busy !== 1'b1 || sizeX !== 5'd0) begin
         bad++; $display("FAIL gap_next_header: got busy=%b sizeX=%0d want 1/0", busy, sizeX); end
      tx_q.delete(); tx_q.push_back(8'h01);
      send_bytes(1, 1'b0, 1);
      wait_done(1, 1);
      total++; if (err_cnt !== 1 || sizeY !== 5'd1 || wr_x_cnt !== 10 || wr_y_cnt !== 5) begin
         bad++; $display("FAIL gap_err_frame: got err=%0d sizeY=%0d wr=%0d/%0d want 1/1/10/5",
                         err_cnt, sizeY, wr_x_cnt, wr_y_cnt); end
   endtask

   task automatic test_zero_sizes();
      int mm;
      clear_obs();
      tx_q.delete(); tx_q.push_back(8'h80); tx_q.push_back(8'h03);
      send_bytes(2, 1'b0, 2);
      wait_done(0, 1);
      total++; if (err_cnt !== 1 || wr_x_cnt + wr_y_cnt !== 0 || start_high_cnt !== 0 || fd_cnt !== 0) begin
         bad++; $display("FAIL zero_err: got err=%0d we=%0d start=%0d fd=%0d want 1/0/0/0",
                         err_cnt, wr_x_cnt + wr_y_cnt, start_high_cnt, fd_cnt); end
      total++; if (shape !== 1'b1 || sizeY !== 5'd3 || sizeX !== 5'd0 || busy !== 1'b0) begin
         bad++; $display("FAIL zero_held: got shape=%b sizeY=%0d sizeX=%0d busy=%b want 1/3/0/0",
                         shape, sizeY, sizeX, busy); end
      clear_obs();
      build_frame($urandom_range(1, 8), $urandom_range(1, 8), 1);
      send_bytes(tx_q.size(), 1'b1, tx_q.size());
      wait_done(1, 0);
      mm = model_mem_mismatch();
      total++; if (mm !== 0 || fd_cnt !== 1 || shape !== 1'b1) begin
         bad++; $display("FAIL zero_next_frame: got mm=%0d fd=%0d shape=%b want 0/1/1", mm, fd_cnt, shape); end
   endtask

   task automatic test_max_size();
      int mm;
      clear_obs();
      build_frame(31, 31, $urandom_range(0, 1));
      send_bytes(tx_q.size(), 1'b0, 0);
      wait_done(1, 0);
      mm = model_mem_mismatch();
      total++; if (mm !== 0) begin bad++; $display("FAIL max_mem: got %0d bad entries want 0", mm); end
      total++; if (wr_x_cnt !== 31 || wr_y_cnt !== 31 || obs_x_wr[31] || obs_y_wr[31]) begin
         bad++; $display("FAIL max_counts: got %0d/%0d a31=%b%b want 31/31/00",
                         wr_x_cnt, wr_y_cnt, obs_x_wr[31], obs_y_wr[31]); end
   endtask

   task automatic test_done_no_busy();
      int mm;
      core_mode = 1;
      clear_obs();
      build_frame(3, 2, 0);
      send_bytes(tx_q.size(), 1'b0, 0);
      wait_done(1, 0);
      mm = model_mem_mismatch();
      total++; if (fd_cnt !== 1 || fd_cyc !== start_rise_cyc + 3) begin
         bad++; $display("FAIL nobusy_done: got %0d@%0d want 1@%0d", fd_cnt, fd_cyc, start_rise_cyc + 3); end
      total++; if (start_high_cnt !== 3 || conv_start !== 1'b0 || mm !== 0) begin
         bad++; $display("FAIL nobusy_start: got len=%0d start=%b mm=%0d want 3/0/0",
                         start_high_cnt, conv_start, mm); end
      core_mode = 0;
   endtask

   task automatic test_reset_mid_load();
      int mm;
      clear_obs();
      build_frame(10, 5, 0);
      send_bytes(6, 1'b0, 0);
      rstn = 1'b0;
      cycle();
      total++; if (all_outs !== 44'd0) begin bad++; $display("FAIL mid_reset_outputs: got %h want 0", all_outs); end
      rstn = 1'b1;
      repeat (5) cycle();
      total++; if (wr_x_cnt !== 4 || wr_y_cnt !== 0 || busy !== 1'b0) begin
         bad++; $display("FAIL mid_reset_writes: got %0d/%0d busy=%b want 4/0/0", wr_x_cnt, wr_y_cnt, busy); end
      clear_obs();
      build_frame($urandom_range(1, 31), $urandom_range(1, 31), 0);
      send_bytes(tx_q.size(), 1'b1, tx_q.size());
      wait_done(1, 0);
      mm = model_mem_mismatch();
      total++; if (mm !== 0 || fd_cnt !== 1) begin
         bad++; $display("FAIL mid_reset_reload: got mm=%0d fd=%0d want 0/1", mm, fd_cnt); end
   endtask

   task automatic test_random_frames();
      int mm;
      int sx, sy;
      for (int f = 0; f < 4; f++) begin
         clear_obs();
         sx = $urandom_range(1, 31); sy = $urandom_range(1, 31);
         build_frame(sx, sy, $urandom_range(0, 1));
         send_bytes(tx_q.size(), 1'b1, tx_q.size());
         wait_done(1, 0);
         mm = model_mem_mismatch();
         total++; if (mm !== 0 || sizeX !== 5'(sx) || sizeY !== 5'(sy) || shape !== tx_q[0][7]) begin
            bad++; $display("FAIL rand_frame%0d: got mm=%0d sizes=%0d/%0d want 0 and %0d/%0d",
                            f, mm, sizeX, sizeY, sx, sy); end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_gappy();
      test_zero_sizes();
      test_max_size();
      test_done_no_busy();
      test_reset_mid_load();
      test_random_frames();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_stream_loader.md
# conv_stream_loader

Upstream feeder for the `convolution` core. Accepts a byte stream carrying one frame (header, X samples, Y samples) over a valid/ready handshake. Writes the samples into the X and Y sample memories and drives `sizeX`/`sizeY`/`shape`. It then starts the convolution and waits for `done` before it accepts the next frame.

## Interface
- DATAWIDTH_X, 8, X sample width; also the stream byte width
- DATAWIDTH_Y, 8, Y sample width; must equal DATAWIDTH_X
- MEM_ADDR_XY_SIZE, 5, X/Y memory address width (32 entries)
- SIZE_X, 5, width of sizeX
- SIZE_Y, 5, width of sizeY

Ports:
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- s_data  in  DATAWIDTH_X  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader can accept a byte; transfer when s_valid && s_ready at a rising edge
- memX_waddr  out  MEM_ADDR_XY_SIZE  X memory write address
- memX_wdata  out  DATAWIDTH_X  X memory write data
- memX_we  out  1  X memory write enable
- memY_waddr  out  MEM_ADDR_XY_SIZE  Y memory write address
- memY_wdata  out  DATAWIDTH_Y  Y memory write data
- memY_we  out  1  Y memory write enable
- sizeX  out  SIZE_X  X length to the convolution core
- sizeY  out  SIZE_Y  Y length to the convolution core
- shape  out  1  shape select to the convolution core
- conv_start  out  1  start request to the convolution core
- conv_busy  in  1  convolution core busy
- conv_done  in  1  convolution core done pulse
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when the convolution completes
- err  out  1  one-cycle pulse when a header is rejected

## Operation
- Frame format:
  - byte0: [4:0] = sizeX, [7] = shape, [6:5] ignored.
  - byte1: [4:0] = sizeY, [7:5] ignored.
  - Then sizeX bytes of X, then sizeY bytes of Y.
- States and transitions:
  - IDLE: accepts byte0 → HDR1.
  - HDR1: accepts byte1. If sizeX == 0 or sizeY == 0 → ERR. Otherwise → LOAD_X.
  - LOAD_X: each accepted byte writes X at address cntX, then cntX++. The byte where cntX == sizeX-1 → LOAD_Y.
  - LOAD_Y: same for Y with cntY. The last byte → FLUSH.
  - FLUSH: one idle cycle → START.
  - START: conv_start = 1. Sampling conv_busy = 1 → RUN. Sampling conv_done = 1 → DONE (covers a core that finishes without showing busy).
  - RUN: conv_start = 0. Sampling conv_done = 1 → DONE.
  - DONE: frame_done = 1 for one cycle → IDLE.
  - ERR: err = 1 for one cycle → IDLE. No memory writes and no conv_start for that frame.
- s_ready = 1 only in IDLE, HDR1, LOAD_X and LOAD_Y. Bytes are never dropped or duplicated. s_valid gaps of any length are tolerated.
- Counters cntX and cntY are MEM_ADDR_XY_SIZE bits wide and are cleared on entry to LOAD_X and LOAD_Y respectively. sizeX = 31 writes addresses 0..30; no wrap occurs.
- sizeX and shape are registered when byte0 is accepted; sizeY is registered when byte1 is accepted. They stay stable until the next byte0 is accepted, including through ERR.
- Stream bytes arriving in START, RUN, DONE or ERR are back-pressured (s_ready = 0).

## Timing
- Reset: rstn = 0 at a rising edge forces state IDLE and clears every counter. From the same edge all outputs read 0: s_ready, every we/addr/data, sizeX, sizeY, shape, conv_start, busy, frame_done, err.
- s_ready after reset: it is 0 while rstn = 0 and becomes 1 the cycle after rstn returns high.
- Reset mid-frame: the partial frame is abandoned, no further writes occur, conv_start drops at that edge, and the first byte after reset is treated as byte0.
- Write latency: a byte accepted at edge k drives we = 1 with its addr/data during cycle k+1 and is written at edge k+1. we is high exactly one cycle per accepted byte, so back-to-back bytes give continuous we.
- Start timing:
  - Last Y byte accepted at edge k: memY_we is high in cycle k+1 (FLUSH).
  - conv_start first goes high in cycle k+2.
  - All memory writes are complete before the core can sample start.
- conv_start is level-held until conv_busy is sampled high, then it deasserts at the following edge.
- frame_done: high for the single cycle after the edge that samples conv_done. s_ready returns to 1 the cycle after that.
- busy is registered; it rises the cycle after byte0 is accepted and falls together with the return to IDLE.

## Test plan
- Nominal frame, continuous valid: byte0 = 0x0A, byte1 = 0x05, X = 1..10, Y = 1..5.
  - memX is written at addresses 0..9 with values 1..10, and memY at 0..4 with 1..5.
  - sizeX = 10, sizeY = 5, shape = 0.
  - conv_start rises 2 cycles after the last Y byte and drops after busy is seen.
  - One frame_done pulse after conv_done.
- Gappy stream: the same frame with s_valid toggling at random, plus a byte presented during RUN.
  - Memory contents are identical to the nominal frame.
  - s_ready = 0 during RUN, and that byte is consumed only after frame_done.
- Zero sizes: byte0 = 0x80, byte1 = 0x03.
  - err pulses once, with no we and no conv_start.
  - shape = 1 and sizeY = 3 are held.
  - The next frame then loads normally.
- Max size: sizeX = 31, sizeY = 31.
  - Addresses 0..30 are written for both memories with no wrap, and address 31 is untouched.
- Done without busy: the core model pulses conv_done while conv_busy stays 0.
  - The loader goes START → DONE, frame_done pulses once, conv_start deasserts.
- Reset mid-load: rstn = 0 for one edge after 4 X bytes.
  - All outputs are 0 at that edge and no further writes occur.
  - The next byte is parsed as a header; a full frame then completes correctly.
